shift_add_multiplier_seq: RTL and testbench

- Sequential unsigned WIDTH x WIDTH multiplier using the shift-and-add method.
- Sits directly upstream and downstream of the team's 4-bit carry-lookahead adder stage:
  - drives the adder's operand and carry-in inputs;
  - consumes the adder's sum and carry-out each add cycle.
- The adder stays a separate combinational instance wired at the parent level.
- Produces a 2*WIDTH-bit product with a start/busy/done handshake.

---
 rtl/shift_add_multiplier_seq_if.sv | 30 +++
 rtl/shift_add_multiplier_seq.sv | 167 ++++++++++++++++
 tb/tb_shift_add_multiplier_seq.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_seq_if.sv
// Request/result bus of the sequential shift-and-add multiplier.
// The requester drives operands and start; the multiplier returns busy, done and product.
interface shift_add_multiplier_seq_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start,
        output multiplicand,
        output multiplier,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/shift_add_multiplier_seq.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier driving an external adder.
// Optional macro MUL_SKIP_ZERO_EN folds the shift into ADD for zero multiplier bits.

module shift_add_multiplier_seq_chk (
    input  logic clk_i,
    input  logic rst_i,
    input  logic busy_i,
    input  logic done_i,
    input  logic add_cin_i
);
    a_busy_done_excl: assert property (@(posedge clk_i) disable iff (rst_i) !(busy_i && done_i));
    a_done_pulse:     assert property (@(posedge clk_i) disable iff (rst_i) done_i |=> !done_i);
    a_cin_zero:       assert property (@(posedge clk_i) disable iff (rst_i) add_cin_i == 1'b0);
    a_reset_quiet:    assert property (@(posedge clk_i) rst_i |=> (!busy_i && !done_i));
endmodule

module shift_add_multiplier_seq #(
    parameter int WIDTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    shift_add_multiplier_seq_if.slave bus,
    output logic [WIDTH-1:0]          add_a_o,
    output logic [WIDTH-1:0]          add_b_o,
    output logic                      add_cin_o,
    input  logic [WIDTH-1:0]          add_s_i,
    input  logic                      add_cout_i
);
    localparam int                CNT_W    = $clog2(WIDTH) + 1;
    localparam int                SR_W     = 2 * WIDTH + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic logic [SR_W-1:0] shr1(input logic [SR_W-1:0] v);
        return {1'b0, v[SR_W-1:1]};
    endfunction

    state_e               state_q,   state_d;
    logic [WIDTH-1:0]     acc_q,     acc_d;
    logic                 carry_q,   carry_d;
    logic [WIDTH-1:0]     mq_q,      mq_d;
    logic [WIDTH-1:0]     m_q,       m_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;
    logic [SR_W-1:0]      shifted_s;

    // Carry from the last add becomes the new top bit of acc_hi.
    assign shifted_s = shr1({carry_q, acc_q, mq_q});

`ifdef MUL_SKIP_ZERO_EN
    logic [SR_W-1:0]      shifted_zero_s;
    assign shifted_zero_s = shr1({1'b0, acc_q, mq_q});
`endif

    assign add_a_o      = acc_q;
    assign add_b_o      = m_q;
    assign add_cin_o    = 1'b0;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.product  = product_q;

    // Next-state and datapath update for the add/shift sequencer.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        mq_d      = mq_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    m_d     = bus.multiplicand;
                    mq_d    = bus.multiplier;
                    acc_d   = {WIDTH{1'b0}};
                    carry_d = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = S_ADD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADD: begin
                if (mq_q[0]) begin
                    acc_d   = add_s_i;
                    carry_d = add_cout_i;
                    state_d = S_SHIFT;
                end else begin
`ifdef MUL_SKIP_ZERO_EN
                    {carry_d, acc_d, mq_d} = shifted_zero_s;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_CNT) begin
                        product_d = shifted_zero_s[2*WIDTH-1:0];
                        state_d   = S_DONE;
                    end else begin
                        state_d   = S_ADD;
                    end
`else
                    carry_d = 1'b0;
                    state_d = S_SHIFT;
`endif
                end
            end
            S_SHIFT: begin
                {carry_d, acc_d, mq_d} = shifted_s;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
                    product_d = shifted_s[2*WIDTH-1:0];
                    state_d   = S_DONE;
                end else begin
                    state_d   = S_ADD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_ADD) || (state_d == S_SHIFT);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            acc_q     <= {WIDTH{1'b0}};
            carry_q   <= 1'b0;
            mq_q      <= {WIDTH{1'b0}};
            m_q       <= {WIDTH{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            product_q <= {(2*WIDTH){1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            mq_q      <= mq_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    shift_add_multiplier_seq_chk u_chk (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .busy_i    (busy_q),
        .done_i    (done_q),
        .add_cin_i (add_cin_o)
    );
endmodule

// File: tb/tb_shift_add_multiplier_seq.sv
// Randomized self-checking bench for shift_add_multiplier_seq with a behavioural 4-bit adder.
module tb_shift_add_multiplier_seq;
    localparam int W = 4;
`ifdef MUL_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic           add_cin;
    logic [W-1:0]   add_s;
    logic           add_cout;
    logic [W:0]     sum_full;
    int             total;
    int             bad;
    int             cout_cnt;

    shift_add_multiplier_seq_if #(.WIDTH(W)) bus ();

    shift_add_multiplier_seq #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .add_a_o    (add_a),
        .add_b_o    (add_b),
        .add_cin_o  (add_cin),
        .add_s_i    (add_s),
        .add_cout_i (add_cout)
    );

    assign sum_full = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    assign add_s    = sum_full[W-1:0];
    assign add_cout = sum_full[W];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.busy && add_cout) cout_cnt <= cout_cnt + 1;
    end

    function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] m, input logic [W-1:0] q);
        int p;
        p = int'(m) * int'(q);
        return p[2*W-1:0];
    endfunction

    function automatic int model_lat(input logic [W-1:0] q);
        return SKIP ? (W + $countones(q)) : (2 * W);
    endfunction

    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                          output int lat, output int busy_n);
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = m;
        bus.multiplier   = q;
        @(negedge clk);
        bus.start        = 1'b0;
        bus.multiplicand = W'($urandom_range(15, 0));
        bus.multiplier   = W'($urandom_range(15, 0));
        lat    = -1;
        busy_n = bus.busy ? 1 : 0;
        for (int k = 1; k <= 3 * W + 4; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total += 6;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        if (bus.product !== 8'h00) begin bad++; $display("FAIL reset_product got=%h want=00", bus.product); end
        if (add_a !== 4'h0) begin bad++; $display("FAIL reset_add_a got=%h want=0", add_a); end
        if (add_b !== 4'h0) begin bad++; $display("FAIL reset_add_b got=%h want=0", add_b); end
        if (add_cin !== 1'b0) begin bad++; $display("FAIL reset_add_cin got=%b want=0", add_cin); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, busy_n;
        run_op(4'h5, 4'h3, lat, busy_n);
        total += 3;
        if (bus.product !== 8'h0F) begin bad++; $display("FAIL basic_product got=%h want=0f", bus.product); end
        if (lat !== model_lat(4'h3)) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", lat, model_lat(4'h3)); end
        if (busy_n !== model_lat(4'h3)) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=%0d", busy_n, model_lat(4'h3)); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total += 2;
            if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", bus.done); end
            if (bus.product !== 8'h0F) begin bad++; $display("FAIL basic_hold got=%h want=0f", bus.product); end
        end
    endtask

    task automatic test_carry();
        int lat, busy_n, c0;
        c0 = cout_cnt;
        run_op(4'hF, 4'hF, lat, busy_n);
        total += 3;
        if (bus.product !== 8'hE1) begin bad++; $display("FAIL carry_product got=%h want=e1", bus.product); end
        if (lat !== model_lat(4'hF)) begin bad++; $display("FAIL carry_latency got=%0d want=%0d", lat, model_lat(4'hF)); end
        if (cout_cnt == c0) begin bad++; $display("FAIL carry_cout_seen got=0 want=nonzero"); end
    endtask

    task automatic test_zero();
        int lat, busy_n;
        run_op(4'h0, 4'h9, lat, busy_n);
        total += 2;
        if (bus.product !== 8'h00) begin bad++; $display("FAIL zero_m_product got=%h want=00", bus.product); end
        if (lat !== model_lat(4'h9)) begin bad++; $display("FAIL zero_m_latency got=%0d want=%0d", lat, model_lat(4'h9)); end
        run_op(4'hA, 4'h0, lat, busy_n);
        total += 2;
        if (bus.product !== 8'h00) begin bad++; $display("FAIL zero_q_product got=%h want=00", bus.product); end
        if (lat !== model_lat(4'h0)) begin bad++; $display("FAIL zero_q_latency got=%0d want=%0d", lat, model_lat(4'h0)); end
    endtask

    task automatic test_ignored_start();
        int lat, busy_n, done_n;
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 4'h6; bus.multiplier = 4'h7;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1; done_n = 0;
        busy_n = bus.busy ? 1 : 0;
        for (int k = 1; k <= 14; k++) begin
            bus.multiplicand = 4'hF; bus.multiplier = 4'hF;
            @(negedge clk);
            if (bus.done) begin
                done_n++;
                if (lat < 0) lat = k;
            end
            if (bus.busy) busy_n++;
            bus.start = (k == 3) || (k == 7) || bus.done;
        end
        bus.start = 1'b0;
        total += 4;
        if (bus.product !== 8'h2A) begin bad++; $display("FAIL ignore_product got=%h want=2a", bus.product); end
        if (done_n !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", done_n); end
        if (lat !== model_lat(4'h7)) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", lat, model_lat(4'h7)); end
        if (busy_n !== model_lat(4'h7)) begin bad++; $display("FAIL ignore_busy_cycles got=%0d want=%0d", busy_n, model_lat(4'h7)); end
    endtask

    task automatic test_reset_mid();
        int lat, busy_n, done_n;
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 4'hF; bus.multiplier = 4'hF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total += 3;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", bus.done); end
        if (bus.product !== 8'h00) begin bad++; $display("FAIL midrst_product got=%h want=00", bus.product); end
        rst = 1'b0;
        done_n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_n++;
        end
        total += 1;
        if (done_n !== 0) begin bad++; $display("FAIL midrst_abandoned got=%0d want=0", done_n); end
        run_op(4'h2, 4'h3, lat, busy_n);
        total += 2;
        if (bus.product !== 8'h06) begin bad++; $display("FAIL midrst_next_product got=%h want=06", bus.product); end
        if (lat !== model_lat(4'h3)) begin bad++; $display("FAIL midrst_next_latency got=%0d want=%0d", lat, model_lat(4'h3)); end
    endtask

    task automatic test_random();
        int lat, busy_n;
        logic [W-1:0] m, q;
        for (int i = 0; i < 30; i++) begin
            m = W'($urandom_range(15, 0));
            q = W'($urandom_range(15, 0));
            run_op(m, q, lat, busy_n);
            total += 2;
            if (bus.product !== model_prod(m, q)) begin
                bad++; $display("FAIL rand_product m=%h q=%h got=%h want=%h", m, q, bus.product, model_prod(m, q));
            end
            if (lat !== model_lat(q)) begin
                bad++; $display("FAIL rand_latency m=%h q=%h got=%0d want=%0d", m, q, lat, model_lat(q));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ms[6];
        logic [W-1:0] qs[6];
        int idx, gap;
        for (int i = 0; i < 6; i++) begin
            ms[i] = W'($urandom_range(15, 0));
            qs[i] = W'($urandom_range(15, 0));
        end
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = ms[0]; bus.multiplier = qs[0];
        idx = 0; gap = 0;
        for (int c = 0; c < 200 && idx < 6; c++) begin
            @(negedge clk);
            gap++;
            if (bus.done) begin
                total += 1;
                if (bus.product !== model_prod(ms[idx], qs[idx])) begin
                    bad++; $display("FAIL b2b_product idx=%0d got=%h want=%h", idx, bus.product, model_prod(ms[idx], qs[idx]));
                end
                if (idx > 0) begin
                    total += 1;
                    if (gap !== model_lat(qs[idx]) + 2) begin
                        bad++; $display("FAIL b2b_spacing idx=%0d got=%0d want=%0d", idx, gap, model_lat(qs[idx]) + 2);
                    end
                end
                idx++; gap = 0;
                if (idx < 6) begin
                    bus.multiplicand = ms[idx]; bus.multiplier = qs[idx];
                end
            end
        end
        bus.start = 1'b0;
        total += 1;
        if (idx !== 6) begin bad++; $display("FAIL b2b_completed got=%0d want=6", idx); end
        repeat (2) @(negedge clk);
    endtask

`ifdef MUL_SKIP_ZERO_EN
    task automatic test_skip_zero();
        int lat, busy_n;
        run_op(4'h7, 4'h8, lat, busy_n);
        total += 2;
        if (bus.product !== 8'h38) begin bad++; $display("FAIL skip_product got=%h want=38", bus.product); end
        if (lat !== 5) begin bad++; $display("FAIL skip_latency_q8 got=%0d want=5", lat); end
        run_op(4'h3, 4'hF, lat, busy_n);
        total += 1;
        if (lat !== 8) begin bad++; $display("FAIL skip_latency_qf got=%0d want=8", lat); end
        run_op(4'h9, 4'h0, lat, busy_n);
        total += 2;
        if (lat !== 4) begin bad++; $display("FAIL skip_latency_q0 got=%0d want=4", lat); end
        if (bus.product !== 8'h00) begin bad++; $display("FAIL skip_product_q0 got=%h want=00", bus.product); end
    endtask
`endif

    initial begin
        total = 0; bad = 0; cout_cnt = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.multiplicand = 4'h0; bus.multiplier = 4'h0;
        test_reset();
        test_basic();
        test_carry();
        test_zero();
        test_ignored_start();
        test_reset_mid();
        test_random();
        test_back_to_back();
`ifdef MUL_SKIP_ZERO_EN
        test_skip_zero();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
